match_ctrl: RTL
===============

# match_ctrl

Board-level controller that drives the per-card control interface of the matching-game grid: one cursor, button-strobe, match-success and match-failure line per card, read back against each card's hidden flag. It owns the cursor position, the two-card selection protocol, symbol comparison and the remaining-pair count. It sits between the debounced button pulses and the ROWS×COLS array of card instances.

## Interface
Parameters:
- ROWS, 4, grid rows
- COLS, 4, grid columns; N = ROWS*COLS, N is even
- SYM_W, 3, symbol width per card
- SHOW_CYC, 4, cycles both selected cards stay visible before the verdict; SHOW_CYC ≥ 2

Ports:
- clk  in  1  the single clock
- rst  in  1  synchronous, active-low reset
- btn_up, btn_down, btn_left, btn_right  in  1 each  single-cycle move pulses
- btn_s  in  1  single-cycle select pulse
- sym  in  N*SYM_W  card symbols; card idx occupies bits [idx*SYM_W +: SYM_W]
- hidden  in  N  per-card hidden flags from the cards
- cur  out  N  one-hot cursor, bit idx = row*COLS+col
- s  out  N  per-card select strobe
- ms  out  N  per-card match-success strobe
- mf  out  N  per-card match-failure strobe
- busy  out  1  high in SHOW state
- pairs_left  out  clog2(N/2+1)  unmatched pairs remaining
- done  out  1  high when pairs_left == 0

## Operation
- Cursor: registered row/col. Each move pulse steps one cell with wrap-around (up from row 0 → ROWS-1, right from COLS-1 → 0). btn_up&btn_down together: no vertical move; btn_left&btn_right together: no horizontal move. Diagonal (one vertical + one horizontal) applies both.
- cur is the one-hot decode of the registered position; exactly one bit set at all times.
- States: IDLE (nothing selected), ONE (first index held in first_idx), SHOW (second index held in second_idx, counting).
- IDLE: btn_s with hidden[cursor]==0 → pulse s[cursor], first_idx←cursor, → ONE. btn_s on hidden card ignored.
- ONE: btn_s on first_idx → pulse s[first_idx], → IDLE (deselect, no ms/mf). btn_s on other non-hidden card → pulse s[cursor], second_idx←cursor, counter←SHOW_CYC, → SHOW. btn_s on hidden card ignored.
- SHOW: btn_s ignored, s never pulsed; cursor moves still accepted. Counter decrements each cycle; on reaching 0: if sym[first_idx]==sym[second_idx] pulse ms on both bits and decrement pairs_left, else pulse mf on both bits; → IDLE.
- s, ms, mf are registered one-cycle pulses; at most one s bit per pulse, ms/mf exactly two bits or zero.
- done: combinational compare of pairs_left with 0; once done, btn_s has no effect (all cards hidden).
- Select uses the cursor position before any move sampled in the same cycle.

## Timing
- Reset (rst low at an edge): cursor at idx 0 (cur = 1), state IDLE, s=ms=mf=0, pairs_left=N/2, busy=0, done=0. Reset mid-SHOW abandons the pair with no ms/mf pulse.
- Move pulse sampled at edge k → cur updated after edge k.
- btn_s sampled at edge k → s bit high from edge k to edge k+1.
- Second btn_s at edge k → busy high from edge k; ms/mf high from edge k+SHOW_CYC+1 to k+SHOW_CYC+2; busy low and state IDLE from that same edge k+SHOW_CYC+1; pairs_left decremented at edge k+SHOW_CYC+1.
- btn_s accepted again in IDLE from edge k+SHOW_CYC+2.
- hidden is used as sampled; a card hidden by ms reports hidden two edges after the ms edge, before any new select can be accepted.

## Test plan
- Reset, ROWS=COLS=4: cur=16'h0001, pairs_left=8, done=0, all strobes 0.
- btn_right ×4 → cur returns to 16'h0001; btn_up at idx 0 → cur=16'h1000; btn_left+btn_right same cycle → cur unchanged.
- sym[0]=sym[5]=3: select idx 0, move to idx 5, select → s pulses at bits 0 and 5; ms=16'h0021 for one cycle exactly SHOW_CYC+1 edges after second btn_s; pairs_left=7; no mf.
- sym[1]=2, sym[2]=6: select 1 then 2 → mf=16'h0006 single cycle, pairs_left unchanged; btn_s during SHOW produces no s pulse.
- Select idx 3 twice → two s pulses on bit 3, state back to IDLE, no ms/mf; rst low during SHOW → no verdict, pairs_left=8.
- Match all 8 pairs → done=1 after last ms; btn_s on any hidden card → no s pulse, state stays IDLE.

Source files
------------

// File: rtl/match_ctrl.sv
// match_ctrl
// Board-level controller for a ROWS x COLS matching-game grid. Owns the
// cursor, the two-card selection protocol, symbol comparison and the
// remaining-pair count, and drives one strobe line per card.
//
// Ports:
//   clk                  single clock
//   rst                  synchronous, active-low reset
//   btn_up/down/left/right  single-cycle cursor move pulses
//   btn_s                single-cycle select pulse
//   sym                  card symbols, card idx at [idx*SYM_W +: SYM_W]
//   hidden               per-card hidden flags read back from the cards
//   cur                  one-hot cursor, bit idx = row*COLS+col
//   s                    per-card select strobe (registered pulse)
//   ms                   per-card match-success strobe (registered pulse)
//   mf                   per-card match-failure strobe (registered pulse)
//   busy                 high while both selected cards are being shown
//   pairs_left           unmatched pairs remaining
//   done                 high when no pairs remain
module match_ctrl #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SYM_W    = 3,
  parameter int SHOW_CYC = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  btn_up,
  input  logic                                  btn_down,
  input  logic                                  btn_left,
  input  logic                                  btn_right,
  input  logic                                  btn_s,
  input  logic [ROWS*COLS*SYM_W-1:0]            sym,
  input  logic [ROWS*COLS-1:0]                  hidden,
  output logic [ROWS*COLS-1:0]                  cur,
  output logic [ROWS*COLS-1:0]                  s,
  output logic [ROWS*COLS-1:0]                  ms,
  output logic [ROWS*COLS-1:0]                  mf,
  output logic                                  busy,
  output logic [$clog2(ROWS*COLS/2+1)-1:0]      pairs_left,
  output logic                                  done
);

  localparam int N   = ROWS * COLS;
  localparam int IW  = (N > 1) ? $clog2(N) : 1;
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int PW  = $clog2(N / 2 + 1);
  localparam int CNW = $clog2(SHOW_CYC + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ONE  = 2'd1,
    SHOW = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [RW-1:0]   row, row_nxt;
  logic [CW-1:0]   col, col_nxt;
  logic [IW-1:0]   cur_idx;
  logic [IW-1:0]   first_idx, first_nxt;
  logic [IW-1:0]   second_idx, second_nxt;
  logic [CNW-1:0]  cnt, cnt_nxt;
  logic [PW-1:0]   pairs_nxt;
  logic [N-1:0]    s_nxt, ms_nxt, mf_nxt;
  logic [SYM_W-1:0] sym_a, sym_b;

  // Cursor next position; opposing pulses in the same axis cancel.
  always_comb begin
    row_nxt = row;
    col_nxt = col;
    if (btn_up && !btn_down)
      row_nxt = (row == '0) ? RW'(ROWS - 1) : row - RW'(1);
    else if (btn_down && !btn_up)
      row_nxt = (row == RW'(ROWS - 1)) ? '0 : row + RW'(1);
    if (btn_left && !btn_right)
      col_nxt = (col == '0) ? CW'(COLS - 1) : col - CW'(1);
    else if (btn_right && !btn_left)
      col_nxt = (col == CW'(COLS - 1)) ? '0 : col + CW'(1);
  end

  // Select decisions use the registered cursor, i.e. before any move
  // sampled in the same cycle.
  assign cur_idx = IW'(row) * IW'(COLS) + IW'(col);
  assign cur     = N'(1) << cur_idx;

  assign sym_a = sym[int'(first_idx) * SYM_W +: SYM_W];
  assign sym_b = sym[int'(second_idx) * SYM_W +: SYM_W];

  assign busy = (state == SHOW);
  assign done = (pairs_left == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      row        <= '0;
      col        <= '0;
      pairs_left <= PW'(N / 2);
      s          <= '0;
      ms         <= '0;
      mf         <= '0;
    end else begin
      state      <= state_nxt;
      row        <= row_nxt;
      col        <= col_nxt;
      pairs_left <= pairs_nxt;
      s          <= s_nxt;
      ms         <= ms_nxt;
      mf         <= mf_nxt;
    end
  end

  // Selection bookkeeping is only meaningful in the states that set it.
  always_ff @(posedge clk) begin
    first_idx  <= first_nxt;
    second_idx <= second_nxt;
    cnt        <= cnt_nxt;
  end

  always_comb begin
    state_nxt  = state;
    first_nxt  = first_idx;
    second_nxt = second_idx;
    cnt_nxt    = cnt;
    pairs_nxt  = pairs_left;
    s_nxt      = '0;
    ms_nxt     = '0;
    mf_nxt     = '0;
    case (state)
      IDLE: begin
        if (btn_s && !done && !hidden[cur_idx]) begin
          s_nxt     = N'(1) << cur_idx;
          first_nxt = cur_idx;
          state_nxt = ONE;
        end
      end
      ONE: begin
        if (btn_s && !hidden[cur_idx]) begin
          s_nxt = N'(1) << cur_idx;
          if (cur_idx == first_idx) begin
            state_nxt = IDLE;
          end else begin
            second_nxt = cur_idx;
            cnt_nxt    = CNW'(SHOW_CYC);
            state_nxt  = SHOW;
          end
        end
      end
      SHOW: begin
        // Counter reaches 0 SHOW_CYC edges after entry; the verdict is
        // registered on the following edge.
        if (cnt == '0) begin
          if (sym_a == sym_b) begin
            ms_nxt    = (N'(1) << first_idx) | (N'(1) << second_idx);
            pairs_nxt = pairs_left - PW'(1);
          end else begin
            mf_nxt = (N'(1) << first_idx) | (N'(1) << second_idx);
          end
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - CNW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
